dm_resp: RTL

DM_RESP -- requirements
Module: dm_resp

---
 rtl/dm_pkg.sv | 20 ++
 rtl/dm_lane_align.sv | 52 +++++
 rtl/dm_resp.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory responder: access sizes, register
// window offsets and the default window base.
package dm_pkg;

    localparam logic [2:0] DM_WORD  = 3'b000;
    localparam logic [2:0] DM_HALF  = 3'b001;
    localparam logic [2:0] DM_HALFU = 3'b010;
    localparam logic [2:0] DM_BYTE  = 3'b011;
    localparam logic [2:0] DM_BYTEU = 3'b100;

    localparam logic [5:0] OFF_CYC    = 6'h00;
    localparam logic [5:0] OFF_STCNT  = 6'h04;
    localparam logic [5:0] OFF_LDCNT  = 6'h08;
    localparam logic [5:0] OFF_LED    = 6'h0C;
    localparam logic [5:0] OFF_STATUS = 6'h10;
    localparam logic [5:0] OFF_FADDR  = 6'h14;

    localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering: byte enables, store data replicated onto the
// addressed lanes, load data shifted down to bit 0, and the misalign flag.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  dm_type_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_sh_o,
    output logic [31:0] rdata_sh_o,
    output logic        misalign_o
);

    // Decode size and low address bits into lane controls.
    always_comb begin
        be_o       = 4'b0000;
        wdata_sh_o = wdata_i;
        rdata_sh_o = 32'd0;
        misalign_o = 1'b0;
        case (dm_type_i)
            DM_WORD: begin
                be_o       = 4'b1111;
                rdata_sh_o = rword_i;
                misalign_o = (addr_lo_i != 2'b00);
            end
            DM_HALF, DM_HALFU: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_sh_o = {2{wdata_i[15:0]}};
                rdata_sh_o = {16'd0, (addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0])};
                misalign_o = addr_lo_i[0];
            end
            DM_BYTE, DM_BYTEU: begin
                be_o       = 4'b0001 << addr_lo_i;
                wdata_sh_o = {4{wdata_i[7:0]}};
                case (addr_lo_i)
                    2'd0:    rdata_sh_o = {24'd0, rword_i[7:0]};
                    2'd1:    rdata_sh_o = {24'd0, rword_i[15:8]};
                    2'd2:    rdata_sh_o = {24'd0, rword_i[23:16]};
                    2'd3:    rdata_sh_o = {24'd0, rword_i[31:24]};
                    default: rdata_sh_o = 32'd0;
                endcase
            end
            default: begin
                // Reserved size codes are rejected like a misaligned access.
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: byte-addressable RAM plus a small register window
// with counters, an LED register and a sticky fault flag with fault address.
module dm_resp
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_w,
    input  logic        mem_r,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [2:0]  DMType,
    output logic [31:0] dout,
    output logic        err,
    output logic [15:0] led
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned AW = IW + 2;

    logic [31:0] ram_q [DEPTH];

    logic [31:0] cyc_q,   cyc_d;
    logic [31:0] st_q,    st_d;
    logic [31:0] ld_q,    ld_d;
    logic [15:0] led_q,   led_d;
    logic        err_q,   err_d;
    logic [31:0] faddr_q, faddr_d;

    logic [IW-1:0] idx_s;
    logic [5:0]    off_s;
    logic          in_ram_s;
    logic          in_mmio_s;
    logic          mis_s;
    logic          fault_s;
    logic          wr_ok_s;
    logic          rd_ok_s;
    logic          ram_we_s;
    logic          status_clr_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_sh_s;
    logic [31:0]   rdata_sh_s;
    logic [31:0]   mmio_rdata_s;
    logic [31:0]   rword_s;

    assign idx_s     = addr[AW-1:2];
    assign off_s     = addr[5:0];
    assign in_ram_s  = ((addr >> AW) == 32'd0);
    assign in_mmio_s = (addr[31:6] == MMIO_BASE[31:6]);

    // Unmapped addresses and non-word register accesses fault like misalignment.
    assign fault_s = (mem_w | mem_r) &
                     (mis_s | ~(in_ram_s | in_mmio_s) | (in_mmio_s & (DMType != DM_WORD)));
    assign wr_ok_s      = mem_w & ~fault_s;
    assign rd_ok_s      = mem_r & ~fault_s;
    assign ram_we_s     = wr_ok_s & in_ram_s & rstn;
    assign status_clr_s = mem_w & in_mmio_s & (off_s == OFF_STATUS);

    // Register window read mux.
    always_comb begin
        case (off_s)
            OFF_CYC:    mmio_rdata_s = cyc_q;
            OFF_STCNT:  mmio_rdata_s = st_q;
            OFF_LDCNT:  mmio_rdata_s = ld_q;
            OFF_LED:    mmio_rdata_s = {16'd0, led_q};
            OFF_STATUS: mmio_rdata_s = {31'd0, err_q};
            OFF_FADDR:  mmio_rdata_s = faddr_q;
            default:    mmio_rdata_s = 32'd0;
        endcase
    end

    assign rword_s = in_ram_s ? ram_q[idx_s] : mmio_rdata_s;

    dm_lane_align u_lane (
        .addr_lo_i  (addr[1:0]),
        .dm_type_i  (DMType),
        .wdata_i    (din),
        .rword_i    (rword_s),
        .be_o       (be_s),
        .wdata_sh_o (wdata_sh_s),
        .rdata_sh_o (rdata_sh_s),
        .misalign_o (mis_s)
    );

    assign dout = rd_ok_s ? rdata_sh_s : 32'd0;
    assign err  = err_q;
    assign led  = led_q;

    // Next-state for counters, LED and fault tracking.
    always_comb begin
        cyc_d   = cyc_q + 32'd1;
        st_d    = st_q;
        ld_d    = ld_q;
        led_d   = led_q;
        err_d   = err_q;
        faddr_d = faddr_q;
        if (wr_ok_s) begin
            st_d = st_q + 32'd1;
        end else if (rd_ok_s) begin
            ld_d = ld_q + 32'd1;
        end else begin
            st_d = st_q;
        end
        if (wr_ok_s && in_mmio_s && (off_s == OFF_LED)) begin
            led_d = din[15:0];
        end else begin
            led_d = led_q;
        end
        // A fault in the same cycle as a clear wins and re-captures the address.
        if (fault_s) begin
            err_d = 1'b1;
            if (!err_q || status_clr_s) begin
                faddr_d = addr;
            end else begin
                faddr_d = faddr_q;
            end
        end else if (status_clr_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_q   <= 32'd0;
            st_q    <= 32'd0;
            ld_q    <= 32'd0;
            led_q   <= 16'd0;
            err_q   <= 1'b0;
            faddr_q <= 32'd0;
        end else begin
            cyc_q   <= cyc_d;
            st_q    <= st_d;
            ld_q    <= ld_d;
            led_q   <= led_d;
            err_q   <= err_d;
            faddr_q <= faddr_d;
        end
    end

    // RAM array with per-byte write enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    ram_q[idx_s][8*i +: 8] <= wdata_sh_s[8*i +: 8];
                end
            end
        end
    end

endmodule
